// File: rtl/tmr_scrub_mon.sv
// TMR voter with scrub sequencer, per-lane error counters and windowed alarm.
// Replica mismatches trigger one scrub load, a settle delay and a stuck re-check.
module tmr_scrub_mon #(
  parameter int dw   = 1,
  parameter int cw   = 8,
  parameter int thr  = 4,
  parameter int win  = 256,
  parameter int hold = 2
) (
  input  logic          c,
  input  logic          r,
  input  logic          e,
  input  logic [dw-1:0] q1,
  input  logic [dw-1:0] q2,
  input  logic [dw-1:0] q3,
  input  logic          clr,
  output logic [dw-1:0] q,
  output logic [dw-1:0] sd,
  output logic          se,
  output logic [2:0]    lane_err,
  output logic [cw-1:0] cnt1,
  output logic [cw-1:0] cnt2,
  output logic [cw-1:0] cnt3,
  output logic          multi,
  output logic          alarm,
  output logic          stuck
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCRUB  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] CHECK  = 2'd3;

  localparam int ww = $clog2(win);
  localparam int hw = (hold > 1) ? $clog2(hold) : 1;

  localparam logic [ww-1:0] wlast = ww'(win - 1);
  localparam logic [hw-1:0] hlast = hw'(hold - 1);
  localparam logic [cw-1:0] cmax  = '1;
  localparam logic [cw-1:0] thr_c = cw'(thr);

  logic [1:0]    st_q, st_d;
  logic [hw-1:0] hc_q, hc_d;
  logic [dw-1:0] sd_q, sd_d;
  logic          se_q, se_d;
  logic [2:0]    lerr_q, lerr_d;
  logic [cw-1:0] c1_q, c1_d;
  logic [cw-1:0] c2_q, c2_d;
  logic [cw-1:0] c3_q, c3_d;
  logic [ww-1:0] wc_q, wc_d;
  logic [cw-1:0] ev_q, ev_d;
  logic          multi_q, multi_d;
  logic          alarm_q, alarm_d;
  logic          stuck_q, stuck_d;
  logic          blk_q, blk_d;

  logic [2:0]    m;
  logic          any_m;
  logic          two_m;
  logic          trig;
  logic          wrap;
  logic [cw-1:0] ev_base;

  assign q     = (q1 & q2) | (q1 & q3) | (q2 & q3);
  assign m     = {|(q3 ^ q), |(q2 ^ q), |(q1 ^ q)};
  assign any_m = |m;
  assign two_m = (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
  assign wrap  = (wc_q == wlast);

  always_comb begin
    st_d    = st_q;
    hc_d    = hc_q;
    sd_d    = sd_q;
    se_d    = 1'b0;
    lerr_d  = e ? m : lerr_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    c3_d    = c3_q;
    multi_d = multi_q;
    alarm_d = alarm_q;
    stuck_d = stuck_q;
    blk_d   = blk_q;
    trig    = 1'b0;
    unique case (st_q)
      IDLE: begin
        // a fault still present after CHECK stays blocked until it clears
        if (!any_m) blk_d = 1'b0;
        if (e && any_m && !blk_q) begin
          trig = 1'b1;
          st_d = SCRUB;
          se_d = 1'b1;
          sd_d = q;
        end
      end
      SCRUB: begin
        st_d = SETTLE;
        hc_d = '0;
      end
      SETTLE: begin
        if (hc_q == hlast) st_d = CHECK;
        else hc_d = hc_q + 1'b1;
      end
      CHECK: begin
        st_d = IDLE;
        if (any_m) begin
          stuck_d = 1'b1;
          blk_d   = 1'b1;
        end
      end
    endcase
    if (trig) begin
      if (m[0] && c1_q != cmax) c1_d = c1_q + 1'b1;
      if (m[1] && c2_q != cmax) c2_d = c2_q + 1'b1;
      if (m[2] && c3_q != cmax) c3_d = c3_q + 1'b1;
      if (two_m) multi_d = 1'b1;
    end
    wc_d    = wrap ? '0 : wc_q + 1'b1;
    ev_base = wrap ? '0 : ev_q;
    ev_d    = (trig && ev_base != cmax) ? ev_base + 1'b1 : ev_base;
    if (ev_d >= thr_c) alarm_d = 1'b1;
    if (clr) begin
      c1_d    = '0;
      c2_d    = '0;
      c3_d    = '0;
      ev_d    = '0;
      multi_d = 1'b0;
      alarm_d = 1'b0;
      stuck_d = 1'b0;
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      st_q    <= IDLE;
      hc_q    <= '0;
      sd_q    <= '0;
      se_q    <= 1'b0;
      lerr_q  <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      c3_q    <= '0;
      wc_q    <= '0;
      ev_q    <= '0;
      multi_q <= 1'b0;
      alarm_q <= 1'b0;
      stuck_q <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      hc_q    <= hc_d;
      sd_q    <= sd_d;
      se_q    <= se_d;
      lerr_q  <= lerr_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
      wc_q    <= wc_d;
      ev_q    <= ev_d;
      multi_q <= multi_d;
      alarm_q <= alarm_d;
      stuck_q <= stuck_d;
      blk_q   <= blk_d;
    end
  end

  assign sd       = sd_q;
  assign se       = se_q;
  assign lane_err = lerr_q;
  assign cnt1     = c1_q;
  assign cnt2     = c2_q;
  assign cnt3     = c3_q;
  assign multi    = multi_q;
  assign alarm    = alarm_q;
  assign stuck    = stuck_q;

endmodule

// File: tb/tb_tmr_scrub_mon.sv
// Bench for tmr_scrub_mon: directed scenarios plus random traffic,
// scored against an event-level reference model.
module tb_tmr_scrub_mon;

  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int THR  = 4;
  localparam int WIN  = 256;
  localparam int HOLD = 2;
  localparam int CMAX = 15;

  logic          c;
  logic          r;
  logic          e;
  logic [DW-1:0] q1, q2, q3;
  logic          clr;
  logic [DW-1:0] q;
  logic [DW-1:0] sd;
  logic          se;
  logic [2:0]    lane_err;
  logic [CW-1:0] cnt1, cnt2, cnt3;
  logic          multi, alarm, stuck;

  tmr_scrub_mon #(
    .dw(DW), .cw(CW), .thr(THR), .win(WIN), .hold(HOLD)
  ) dut (
    .c(c), .r(r), .e(e),
    .q1(q1), .q2(q2), .q3(q3),
    .clr(clr),
    .q(q), .sd(sd), .se(se),
    .lane_err(lane_err),
    .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
    .multi(multi), .alarm(alarm), .stuck(stuck)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  typedef struct {
    int            cyc;
    logic [DW-1:0] sd;
    int            c1;
    int            c2;
    int            c3;
  } exp_t;

  exp_t sbq[$];

  int ncmp = 0;
  int nfail = 0;
  int ncyc = 0;
  int se_seen = 0;
  bit started = 0;

  // reference model state
  int            since_rst = 0;
  int            ev_win = 0;
  int            ev = 0;
  int            pos = 0;
  bit            blocked = 0;
  int            mc[3];
  bit            m_multi = 0, m_alarm = 0, m_stuck = 0;
  logic [DW-1:0] m_sd = '0;
  logic [2:0]    m_lerr = '0;

  function automatic logic [DW-1:0] maj(input logic [DW-1:0] a,
                                        input logic [DW-1:0] b,
                                        input logic [DW-1:0] d);
    logic [DW-1:0] o;
    for (int i = 0; i < DW; i++) begin
      int v;
      v = int'(a[i]) + int'(b[i]) + int'(d[i]);
      o[i] = (v >= 2);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                 nm, act, exp, ncyc);
    end
  endtask

  always @(posedge c) begin
    ncyc++;
    if (r) begin
      started = 1;
      since_rst = 0;
      ev_win = 0;
      ev = 0;
      pos = 0;
      blocked = 0;
      for (int i = 0; i < 3; i++) mc[i] = 0;
      m_multi = 0; m_alarm = 0; m_stuck = 0;
      m_sd = '0; m_lerr = '0;
      sbq.delete();
    end else begin
      logic [DW-1:0] mj;
      logic [2:0]    mm;
      bit            any, trig;
      int            nm, tw;
      mj = maj(q1, q2, q3);
      mm = {q3 != mj, q2 != mj, q1 != mj};
      any = (mm != 0);
      nm = int'(mm[0]) + int'(mm[1]) + int'(mm[2]);
      trig = 0;
      if (pos == 0) begin
        if (!any) blocked = 0;
        if (e && any && !blocked) begin
          trig = 1;
          pos = 1;
          m_sd = mj;
        end
      end else if (pos == HOLD + 2) begin
        if (any) begin
          m_stuck = 1;
          blocked = 1;
        end
        pos = 0;
      end else begin
        pos++;
      end
      if (e) m_lerr = mm;
      tw = (since_rst + 1) / WIN;
      if (tw != ev_win) begin
        ev_win = tw;
        ev = 0;
      end
      if (trig) begin
        for (int i = 0; i < 3; i++)
          if (mm[i] && mc[i] < CMAX) mc[i]++;
        if (nm >= 2) m_multi = 1;
        if (ev < CMAX) ev++;
        if (ev >= THR) m_alarm = 1;
      end
      since_rst++;
      if (clr) begin
        for (int i = 0; i < 3; i++) mc[i] = 0;
        ev = 0;
        m_multi = 0; m_alarm = 0; m_stuck = 0;
      end
      if (trig) sbq.push_back('{ncyc, m_sd, mc[0], mc[1], mc[2]});
    end
  end

  always @(negedge c) begin
    if (started) begin
      bit exp_se;
      chk("vote_q", 32'(q), 32'(maj(q1, q2, q3)));
      chk("lane_err", 32'(lane_err), 32'(m_lerr));
      chk("cnt1", 32'(cnt1), 32'(mc[0]));
      chk("cnt2", 32'(cnt2), 32'(mc[1]));
      chk("cnt3", 32'(cnt3), 32'(mc[2]));
      chk("multi", 32'(multi), 32'(m_multi));
      chk("alarm", 32'(alarm), 32'(m_alarm));
      chk("stuck", 32'(stuck), 32'(m_stuck));
      exp_se = (sbq.size() > 0) && (sbq[0].cyc == ncyc);
      chk("se", 32'(se), 32'(exp_se));
      if (se === 1'b1) se_seen++;
      if (sbq.size() > 0 && sbq[0].cyc <= ncyc) begin
        exp_t x;
        x = sbq.pop_front();
        if (se === 1'b1) begin
          chk("sb_sd", 32'(sd), 32'(x.sd));
          chk("sb_cnt1", 32'(cnt1), 32'(x.c1));
          chk("sb_cnt2", 32'(cnt2), 32'(x.c2));
          chk("sb_cnt3", 32'(cnt3), 32'(x.c3));
        end
      end
    end
  end

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    q1 = v; q2 = v; q3 = v;
  endtask

  task automatic glitch(input int lane, input logic [DW-1:0] mask,
                        input int gap);
    logic [DW-1:0] a, b, d;
    a = q1; b = q2; d = q3;
    if (lane == 0) q1 = a ^ mask;
    else if (lane == 1) q2 = b ^ mask;
    else q3 = d ^ mask;
    tick();
    q1 = a; q2 = b; q3 = d;
    repeat (gap - 1) tick();
  endtask

  task automatic do_reset();
    r = 1;
    tick();
    r = 0;
  endtask

  task automatic wait_win(input int tgt);
    int g;
    g = 0;
    while (since_rst != tgt && g < 2 * WIN) begin
      tick();
      g++;
    end
    chk("win_align", 32'(since_rst), 32'(tgt));
  endtask

  initial begin
    int s0;
    logic [DW-1:0] base;
    int pl, pleft;
    logic [DW-1:0] pmask;
    r = 1; e = 0; clr = 0;
    set_all('0);
    repeat (3) tick();
    r = 0;
    chk("rst_sd", 32'(sd), 32'h0);
    chk("rst_se", 32'(se), 32'h0);

    // all replicas agree
    e = 1;
    set_all(8'h5A);
    repeat (20) tick();
    chk("agree_no_se", 32'(se_seen), 32'd0);
    chk("agree_cnt1", 32'(cnt1), 32'd0);

    // single-cycle upset on lane 2
    q2 = 8'h5B;
    tick();
    chk("up_lane_err", 32'(lane_err), 32'b010);
    chk("up_se", 32'(se), 32'd1);
    q2 = 8'h5A;
    repeat (8) tick();
    chk("up_sd", 32'(sd), 32'h5A);
    chk("up_cnt2", 32'(cnt2), 32'd1);
    chk("up_multi", 32'(multi), 32'd0);
    chk("up_pulses", 32'(se_seen), 32'd1);

    // persistent fault on lane 1
    q1 = 8'hFF; q2 = 8'h00; q3 = 8'h00;
    repeat (15) tick();
    chk("stk_stuck", 32'(stuck), 32'd1);
    chk("stk_pulses", 32'(se_seen), 32'd2);
    set_all('0);
    repeat (4) tick();

    // two lanes wrong in different bits
    clr = 1;
    tick();
    clr = 0;
    q1 = 8'h01; q2 = 8'h02; q3 = 8'h00;
    #1;
    chk("two_q", 32'(q), 32'h0);
    tick();
    set_all('0);
    repeat (8) tick();
    chk("two_multi", 32'(multi), 32'd1);
    chk("two_cnt1", 32'(cnt1), 32'd1);
    chk("two_cnt2", 32'(cnt2), 32'd1);

    // clear coincides with an event
    q3 = 8'h10;
    clr = 1;
    tick();
    q3 = 8'h00;
    clr = 0;
    repeat (6) tick();
    chk("clr_cnt3", 32'(cnt3), 32'd0);
    chk("clr_multi", 32'(multi), 32'd0);

    // reset during SETTLE
    q1 = 8'h04;
    tick();
    q1 = 8'h00;
    tick();
    s0 = se_seen;
    do_reset();
    chk("abort_se", 32'(se), 32'd0);
    chk("abort_sd", 32'(sd), 32'd0);
    chk("abort_le", 32'(lane_err), 32'd0);
    repeat (8) tick();
    chk("abort_pulses", 32'(se_seen), 32'(s0));

    // THR events inside one window
    repeat (10) tick();
    for (int i = 0; i < THR; i++) glitch(1, 8'h80, 10);
    chk("win_alarm", 32'(alarm), 32'd1);

    // three events, wrap, one event
    do_reset();
    wait_win(200);
    for (int i = 0; i < 3; i++) glitch(2, 8'h01, 10);
    wait_win(260);
    glitch(0, 8'h02, 10);
    chk("wrap_noalarm", 32'(alarm), 32'd0);

    // event exactly on the wrap edge counts in the new window
    do_reset();
    wait_win(100);
    for (int i = 0; i < 3; i++) glitch(0, 8'h08, 10);
    wait_win(WIN - 1);
    glitch(1, 8'h08, 10);
    chk("edge_noalarm", 32'(alarm), 32'd0);
    for (int i = 0; i < 3; i++) glitch(2, 8'h08, 10);
    chk("edge_alarm", 32'(alarm), 32'd1);

    // counter saturation
    clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < CMAX + 5; i++) glitch(2, 8'h40, 6);
    chk("sat_cnt3", 32'(cnt3), 32'(CMAX));

    // random traffic
    base = '0;
    pl = 0; pleft = 0; pmask = '0;
    for (int n = 0; n < 4000; n++) begin
      e = ($urandom_range(0, 99) < 90);
      clr = ($urandom_range(0, 99) == 0);
      r = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 49) == 0) base = DW'($urandom);
      set_all(base);
      if (pleft > 0) pleft--;
      else if ($urandom_range(0, 199) == 0) begin
        pl = $urandom_range(0, 2);
        pmask = DW'($urandom_range(1, 255));
        pleft = $urandom_range(5, 40);
      end
      if (pleft > 0) begin
        if (pl == 0) q1 = base ^ pmask;
        else if (pl == 1) q2 = base ^ pmask;
        else q3 = base ^ pmask;
      end else if ($urandom_range(0, 99) < 10) begin
        q1 = base ^ (($urandom_range(0, 3) == 0) ? DW'($urandom) : '0);
        q2 = base ^ (($urandom_range(0, 3) == 0) ? DW'($urandom) : '0);
        q3 = base ^ (($urandom_range(0, 3) == 0) ? DW'($urandom) : '0);
      end
      tick();
    end
    r = 0; clr = 0; e = 1;
    set_all(base);
    repeat (12) tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_mon.md
TMR_SCRUB_MON -- requirements
Module: tmr_scrub_mon

Interface
REQ-001 SHALL have parameter dw, default 1, meaning the width of each replica and the voted word.
REQ-002 SHALL have parameter cw, default 8, meaning the width of each per-lane error counter.
REQ-003 SHALL have parameter thr, default 4, meaning the number of scrub events within one window that raises alarm; legal range 1..2^cw-1.
REQ-004 SHALL have parameter win, default 256, meaning the window length in clock cycles; legal range >= 2.
REQ-005 SHALL have parameter hold, default 2, meaning the settle cycles after a scrub before re-check; legal range >= 1.
REQ-006 SHALL have port c, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port r, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port e, input, 1 bit: monitor enable.
REQ-009 SHALL have ports q1, q2, q3, input, dw bits each: the three replica outputs of the upstream triple register.
REQ-010 SHALL have port clr, input, 1 bit: clears counters, alarm and stuck.
REQ-011 SHALL have port q, output, dw bits: combinational bitwise majority of q1, q2, q3.
REQ-012 SHALL have port sd, output, dw bits: registered scrub data.
REQ-013 SHALL have port se, output, 1 bit: one-cycle scrub-load pulse to the upstream enable.
REQ-014 SHALL have port lane_err, output, 3 bits: registered per-lane mismatch (bit0=q1).
REQ-015 SHALL have ports cnt1, cnt2, cnt3, output, cw bits each: saturating per-lane error counts.
REQ-016 SHALL have ports multi, alarm, stuck, output, 1 bit each: sticky status flags.

Function
REQ-017 SHALL compute mismatch vector m[i] = |(qi ^ q) each cycle.
REQ-018 SHALL register lane_err <= m every cycle when e=1, and hold it when e=0.
REQ-019 SHALL implement FSM states IDLE, SCRUB, SETTLE, CHECK, encoded as 2 bits.
REQ-020 SHALL transition IDLE->SCRUB when e=1 and |m; otherwise it SHALL stay in IDLE.
REQ-021 SHALL, on the IDLE->SCRUB edge, latch sd <= q and increment cnti for each set m[i], saturating at 2^cw-1.
REQ-022 SHALL, in SCRUB, assert se=1 for exactly that one cycle, then go to SETTLE.
REQ-023 SHALL make se high on cycle N+1 when a mismatch is sampled on cycle N.
REQ-024 SHALL, in SETTLE, count hold cycles while ignoring m and e, then go to CHECK.
REQ-025 SHALL, in CHECK, set stuck if |m, and SHALL return to IDLE unconditionally.
REQ-026 SHALL NOT let a persistent fault re-trigger SCRUB; the next mismatch sampled in IDLE is a new event.
REQ-027 SHALL set multi when two or more bits of m are set on the IDLE->SCRUB edge.
REQ-028 SHALL run a free-running window counter 0..win-1 and an event counter counting IDLE->SCRUB edges.
REQ-029 SHALL set alarm when the event count reaches thr within the current window.
REQ-030 SHALL clear the event count at window wrap; if an event coincides with wrap, it SHALL count as 1 in the new window.
REQ-031 SHALL, when clr=1, zero cnt1..cnt3, the event count, alarm, multi and stuck, with clr taking priority over a simultaneous increment.
REQ-032 SHALL NOT affect the FSM or sd via clr.
REQ-033 SHALL hold the FSM in IDLE when e=0, except to finish an in-flight SCRUB/SETTLE/CHECK sequence.

Reset
REQ-034 SHALL, while r=1 at a clock edge, drive FSM=IDLE, se=0, sd=0, lane_err=0, cnt1..cnt3=0, window and event counters=0, and multi=alarm=stuck=0.
REQ-035 SHALL, when r asserts mid-sequence (SCRUB or SETTLE), abort the sequence with no further se pulse.
REQ-036 SHALL give r priority over clr and e.

Verification
REQ-037 SHALL cover: dw=8, q1=q2=q3=0x5A -> q=0x5A, se never asserts, all counts 0.
REQ-038 SHALL cover: q2=0x5B for one cycle, e=1 -> se pulse on next cycle, sd=0x5A, cnt2=1, lane_err=3'b010, multi=0.
REQ-039 SHALL cover: q1 held at 0xFF, others 0x00 -> one se pulse, stuck=1 after 1+hold+1 cycles, no second pulse.
REQ-040 SHALL cover: thr=4 events spaced 10 cycles inside win=256 -> alarm=1 after the 4th; 3 events then wrap then 1 event -> alarm=0.
REQ-041 SHALL cover: q1=0x01, q2=0x02, q3=0x00 -> q=0x00, multi=1, cnt1=cnt2=1.
REQ-042 SHALL cover: r pulsed during SETTLE -> all outputs 0 next cycle; clr with a simultaneous event -> counts 0.
